// File: rtl/fetch_queue.sv
// Circular instruction queue between the fetch stage and decode: up to FETCH_W
// in-order pushes and ISSUE_W in-order pops per cycle, flushed on redirect.
module fetch_queue #(
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 8,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic [FETCH_W-1:0]     push_valid_i,
    input  logic [FETCH_W*32-1:0]  push_pc_i,
    input  logic [FETCH_W*32-1:0]  push_instr_i,
    output logic                   push_ready_o,
    output logic [ISSUE_W-1:0]     out_valid_o,
    output logic [ISSUE_W*32-1:0]  out_pc_o,
    output logic [ISSUE_W*32-1:0]  out_pcplus4_o,
    output logic [ISSUE_W*32-1:0]  out_instr_o,
    input  logic [ISSUE_W-1:0]     pop_i,
    output logic [CW-1:0]          count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [CW-1:0] push_len;
    logic [CW-1:0] push_acc;
    logic [CW-1:0] pop_raw;
    logic [CW-1:0] pop_len;
    logic          push_run;
    logic          pop_run;

    // Ready looks only at the registered count; same-cycle pops earn no credit.
    assign push_ready_o = (CW'(DEPTH) - count) >= CW'(FETCH_W);

    always_comb begin
        push_len = '0;
        push_run = 1'b1;
        for (int unsigned k = 0; k < FETCH_W; k++) begin
            push_run = push_run & push_valid_i[k];
            if (push_run) push_len = push_len + CW'(1);
        end
        push_acc = push_ready_o ? push_len : '0;
    end

    always_comb begin
        pop_raw = '0;
        pop_run = 1'b1;
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            pop_run = pop_run & pop_i[k];
            if (pop_run) pop_raw = pop_raw + CW'(1);
        end
        pop_len = (pop_raw > count) ? count : pop_raw;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop_len);
            tail  <= tail + PW'(push_acc);
            count <= count + push_acc - pop_len;
        end
    end

    // Storage carries no reset; only the occupancy state defines validity.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i) begin
            for (int unsigned k = 0; k < FETCH_W; k++) begin
                if (CW'(k) < push_acc) begin
                    pc_mem[tail + PW'(k)]    <= push_pc_i[32*k +: 32];
                    instr_mem[tail + PW'(k)] <= push_instr_i[32*k +: 32];
                end
            end
        end
    end

    always_comb begin
        out_valid_o   = '0;
        out_pc_o      = '0;
        out_pcplus4_o = '0;
        out_instr_o   = '0;
        for (int unsigned j = 0; j < ISSUE_W; j++) begin
            out_valid_o[j]          = CW'(j) < count;
            out_pc_o[32*j +: 32]      = pc_mem[head + PW'(j)];
            out_pcplus4_o[32*j +: 32] = pc_mem[head + PW'(j)] + 32'd4;
            out_instr_o[32*j +: 32]   = instr_mem[head + PW'(j)];
        end
    end

    assign count_o = count;
    assign empty_o = (count == '0);
    assign full_o  = (count == CW'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: table of vectors checked against a queue scoreboard,
// plus hand sequences for full/drop, flush, PC+4 wrap and async reset.
module tb_fetch_queue;

    localparam int FW = 2;
    localparam int IW = 2;
    localparam int D  = 8;
    localparam int CW = $clog2(D + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush_i = 1'b0;
    logic [FW-1:0]   push_valid_i = '0;
    logic [FW*32-1:0] push_pc_i = '0;
    logic [FW*32-1:0] push_instr_i = '0;
    logic            push_ready_o;
    logic [IW-1:0]   out_valid_o;
    logic [IW*32-1:0] out_pc_o;
    logic [IW*32-1:0] out_pcplus4_o;
    logic [IW*32-1:0] out_instr_o;
    logic [IW-1:0]   pop_i = '0;
    logic [CW-1:0]   count_o;
    logic            empty_o;
    logic            full_o;

    fetch_queue #(.FETCH_W(FW), .ISSUE_W(IW), .DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .push_valid_i (push_valid_i),
        .push_pc_i    (push_pc_i),
        .push_instr_i (push_instr_i),
        .push_ready_o (push_ready_o),
        .out_valid_o  (out_valid_o),
        .out_pc_o     (out_pc_o),
        .out_pcplus4_o(out_pcplus4_o),
        .out_instr_o  (out_instr_o),
        .pop_i        (pop_i),
        .count_o      (count_o),
        .empty_o      (empty_o),
        .full_o       (full_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef struct {
        logic        flush;
        logic [1:0]  pv;
        logic [1:0]  pop;
        logic [31:0] base;
        int          exp_count;
        int          tag;      // 1 full/not-ready, 2 empty, 3 slot0 is 0x100, 4 PC+4 wrap
    } vec_t;

    entry_t model_q[$];
    vec_t   vecs[$];
    int     n_pass = 0;
    int     n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic f, input logic [1:0] pv, input logic [1:0] pp,
                       input logic [31:0] base, input int ec, input int tag);
        vec_t v;
        v.flush = f; v.pv = pv; v.pop = pp; v.base = base; v.exp_count = ec; v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic check_state();
        int sz;
        sz = model_q.size();
        chk("count", 64'(count_o), 64'(sz));
        chk("empty", 64'(empty_o), 64'(sz == 0));
        chk("full", 64'(full_o), 64'(sz == D));
        chk("ready", 64'(push_ready_o), 64'((D - sz) >= FW));
        for (int j = 0; j < IW; j++) begin
            chk("valid", 64'(out_valid_o[j]), 64'(j < sz));
            if (j < sz) begin
                chk("pc", 64'(out_pc_o[32*j +: 32]), 64'(model_q[j].pc));
                chk("pcplus4", 64'(out_pcplus4_o[32*j +: 32]), 64'(32'(model_q[j].pc + 32'd4)));
                chk("instr", 64'(out_instr_o[32*j +: 32]), 64'(model_q[j].instr));
            end
        end
    endtask

    // Scoreboard update for one edge, computed from the pre-edge model state.
    task automatic model_step(input logic f, input logic [1:0] pv, input logic [1:0] pp,
                              input logic [31:0] base);
        int q, p;
        bit ready;
        entry_t e;
        ready = (D - model_q.size()) >= FW;
        if (f) begin
            model_q.delete();
            return;
        end
        q = pp[0] ? (pp[1] ? 2 : 1) : 0;
        if (q > model_q.size()) q = model_q.size();
        repeat (q) void'(model_q.pop_front());
        p = pv[0] ? (pv[1] ? 2 : 1) : 0;
        if (ready) begin
            for (int k = 0; k < p; k++) begin
                e.pc = base + 32'(4 * k);
                e.instr = ~e.pc;
                model_q.push_back(e);
            end
        end
    endtask

    task automatic drive_cycle(input logic f, input logic [1:0] pv, input logic [1:0] pp,
                               input logic [31:0] base);
        flush_i = f;
        push_valid_i = pv;
        pop_i = pp;
        push_pc_i = {base + 32'd4, base};
        push_instr_i = {~(base + 32'd4), ~base};
        model_step(f, pv, pp, base);
        @(posedge clk);
        @(negedge clk);
        flush_i = 1'b0;
        push_valid_i = '0;
        pop_i = '0;
        check_state();
    endtask

    initial begin
        // fill and drop
        add(0, 2'b11, 2'b00, 32'h00, 2, 0);
        add(0, 2'b11, 2'b00, 32'h08, 4, 0);
        add(0, 2'b11, 2'b00, 32'h10, 6, 0);
        add(0, 2'b11, 2'b00, 32'h18, 8, 1);
        add(0, 2'b11, 2'b00, 32'h20, 8, 1);
        add(0, 2'b00, 2'b11, 32'h0, 6, 0);
        add(0, 2'b00, 2'b11, 32'h0, 4, 0);
        add(0, 2'b00, 2'b11, 32'h0, 2, 0);
        add(0, 2'b00, 2'b11, 32'h0, 0, 2);
        // order across the 7->0 boundary
        add(0, 2'b11, 2'b00, 32'h40, 2, 0);
        add(0, 2'b11, 2'b00, 32'h48, 4, 0);
        add(0, 2'b11, 2'b00, 32'h50, 6, 0);
        add(0, 2'b11, 2'b11, 32'h58, 6, 0);
        add(0, 2'b11, 2'b11, 32'h60, 6, 0);
        add(0, 2'b00, 2'b11, 32'h0, 4, 0);
        add(0, 2'b00, 2'b11, 32'h0, 2, 0);
        add(0, 2'b00, 2'b11, 32'h0, 0, 2);
        // simultaneous push/pop
        add(0, 2'b11, 2'b00, 32'h80, 2, 0);
        add(0, 2'b01, 2'b00, 32'h88, 3, 0);
        add(0, 2'b11, 2'b11, 32'h90, 3, 0);
        // partial / illegal masks, pop clipped to count
        add(0, 2'b10, 2'b00, 32'hA0, 3, 0);
        add(0, 2'b00, 2'b10, 32'h0, 3, 0);
        add(0, 2'b00, 2'b11, 32'h0, 1, 0);
        add(0, 2'b00, 2'b11, 32'h0, 0, 2);
        // flush priority, then latency-1 visibility
        add(0, 2'b11, 2'b00, 32'hB0, 2, 0);
        add(0, 2'b11, 2'b00, 32'hB8, 4, 0);
        add(0, 2'b11, 2'b00, 32'hC0, 6, 0);
        add(1, 2'b11, 2'b01, 32'hC8, 0, 2);
        add(0, 2'b01, 2'b00, 32'h100, 1, 3);
        add(0, 2'b11, 2'b00, 32'hFFFF_FFF8, 3, 0);
        add(0, 2'b00, 2'b01, 32'h0, 2, 4);
        add(0, 2'b01, 2'b00, 32'h200, 3, 0);
        add(0, 2'b11, 2'b00, 32'h208, 5, 0);

        repeat (2) @(negedge clk);
        check_state();
        chk("rst_valid", 64'(out_valid_o), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive_cycle(vecs[i].flush, vecs[i].pv, vecs[i].pop, vecs[i].base);
            chk($sformatf("vec%0d_count", i), 64'(count_o), 64'(vecs[i].exp_count));
            case (vecs[i].tag)
                1: begin
                    chk("full_flag", 64'(full_o), 64'(1));
                    chk("ready_low", 64'(push_ready_o), 64'(0));
                end
                2: chk("empty_flag", 64'(empty_o), 64'(1));
                3: chk("flush_then_push", 64'(out_pc_o[31:0]), 64'(32'h100));
                4: begin
                    chk("pc_slot1", 64'(out_pc_o[63:32]), 64'(32'hFFFF_FFFC));
                    chk("pc4_wrap", 64'(out_pcplus4_o[63:32]), 64'(0));
                end
                default: ;
            endcase
        end

        // async reset mid-stream with five entries held
        rst = 1'b1;
        #1;
        chk("async_count", 64'(count_o), 64'(0));
        chk("async_empty", 64'(empty_o), 64'(1));
        chk("async_valid", 64'(out_valid_o), 64'(0));
        chk("async_ready", 64'(push_ready_o), 64'(1));
        model_q.delete();
        @(negedge clk);
        rst = 1'b0;
        drive_cycle(1'b0, 2'b11, 2'b00, 32'h300);
        chk("post_rst_count", 64'(count_o), 64'(2));
        chk("post_rst_pc", 64'(out_pc_o[31:0]), 64'(32'h300));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
